// File: rtl/spi_flash_reader.sv
// spi_flash_reader: acts as bus master on the spi register port and streams
// bytes out of a SPI NOR flash using the READ (0x03) command.
module spi_flash_reader #(
    parameter int LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [23:0]      i_faddr,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_spi_addr,
    output logic             o_spi_cs,
    output logic             o_spi_we,
    output logic [7:0]       o_spi_dat,
    input  logic [7:0]       i_spi_dat,
    input  logic             i_spi_irq
);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_SEL, S_CMD, S_A2, S_A1, S_A0,
        S_RD, S_OUT, S_DESEL, S_FIN
    } state_t;

    state_t           state;
    logic             phase;
    logic [23:0]      faddr;
    logic [LEN_W-1:0] remaining;

    function automatic state_t next_byte_state(input state_t s);
        case (s)
            S_CMD:   return S_A2;
            S_A2:    return S_A1;
            S_A1:    return S_A0;
            default: return S_RD;
        endcase
    endfunction

    function automatic logic [7:0] tx_byte(input state_t s, input logic [23:0] a);
        case (s)
            S_CMD:   return 8'h03;
            S_A2:    return a[23:16];
            S_A1:    return a[15:8];
            S_A0:    return a[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // Outputs are registered for the state being entered, so each state's bus
    // action appears in the cycle it is resident. phase: 0 = write, 1 = wait.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_INIT;
            phase      <= 1'b0;
            faddr      <= '0;
            remaining  <= '0;
            o_busy     <= 1'b1;
            o_done     <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_spi_addr <= 1'b0;
            o_spi_cs   <= 1'b0;
            o_spi_we   <= 1'b0;
            o_spi_dat  <= '0;
        end else begin
            o_spi_cs   <= 1'b0;
            o_spi_we   <= 1'b0;
            o_spi_addr <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                S_INIT: begin
                    if (!phase) begin
                        o_spi_cs  <= 1'b1;
                        o_spi_we  <= 1'b1;
                        o_spi_dat <= 8'h01;
                        phase     <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        phase  <= 1'b0;
                        o_busy <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (i_start) begin
                        faddr     <= i_faddr;
                        remaining <= i_len;
                        o_busy    <= 1'b1;
                        if (i_len == '0) begin
                            state <= S_FIN;
                        end else begin
                            state     <= S_SEL;
                            o_spi_cs  <= 1'b1;
                            o_spi_we  <= 1'b1;
                            o_spi_dat <= 8'h00;
                        end
                    end
                end
                S_SEL: begin
                    state      <= S_CMD;
                    phase      <= 1'b0;
                    o_spi_cs   <= 1'b1;
                    o_spi_we   <= 1'b1;
                    o_spi_addr <= 1'b1;
                    o_spi_dat  <= tx_byte(S_CMD, faddr);
                end
                S_CMD, S_A2, S_A1, S_A0, S_RD: begin
                    o_spi_cs   <= 1'b1;
                    o_spi_addr <= 1'b1;
                    if (!phase) begin
                        phase <= 1'b1;
                    end else if (i_spi_irq) begin
                        phase <= 1'b0;
                        if (state == S_RD) begin
                            o_data     <= i_spi_dat;
                            o_valid    <= 1'b1;
                            state      <= S_OUT;
                            o_spi_cs   <= 1'b0;
                            o_spi_addr <= 1'b0;
                        end else begin
                            state     <= next_byte_state(state);
                            o_spi_we  <= 1'b1;
                            o_spi_dat <= tx_byte(next_byte_state(state), faddr);
                        end
                    end
                end
                S_OUT: begin
                    if (i_ready) begin
                        o_valid   <= 1'b0;
                        remaining <= remaining - LEN_W'(1);
                        o_spi_cs  <= 1'b1;
                        o_spi_we  <= 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state     <= S_DESEL;
                            o_spi_dat <= 8'h01;
                        end else begin
                            state      <= S_RD;
                            phase      <= 1'b0;
                            o_spi_addr <= 1'b1;
                            o_spi_dat  <= 8'h00;
                        end
                    end
                end
                S_DESEL: begin
                    state  <= S_FIN;
                    o_done <= 1'b1;
                end
                S_FIN: begin
                    // A zero-length request enters FIN with o_done low and
                    // raises it one cycle later; DESEL enters with it high.
                    if (!o_done) begin
                        o_done <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: a flash/spi responder, a transaction-level
// model of expected bus writes and byte stream, and a per-cycle monitor.
module tb_spi_flash_reader;

    logic        clk, rst, start, ready;
    logic [23:0] faddr;
    logic [15:0] len;
    logic        busy, done, valid;
    logic [7:0]  data;
    logic        spi_addr, spi_cs, spi_we;
    logic [7:0]  spi_dat, spi_rdat;
    logic        spi_irq;

    spi_flash_reader #(.LEN_W(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_faddr(faddr), .i_len(len),
        .o_busy(busy), .o_done(done), .o_data(data), .o_valid(valid), .i_ready(ready),
        .o_spi_addr(spi_addr), .o_spi_cs(spi_cs), .o_spi_we(spi_we), .o_spi_dat(spi_dat),
        .i_spi_dat(spi_rdat), .i_spi_irq(spi_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vec = 0, err = 0, done_cnt = 0;
    logic [8:0]  exp_wr[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  flash_q[$];
    int unsigned lat = 3;
    logic        stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vec++;
        if (act !== req) begin
            err++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Flash/spi responder: irq `lat` cycles after each rx/tx write.
    int unsigned resp_idx = 0, pend = 0;
    logic [7:0]  pdat;
    initial begin
        spi_irq = 1'b0; spi_rdat = 8'hEE;
        forever begin
            @(posedge clk); #1;
            spi_irq = 1'b0; spi_rdat = 8'hEE;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin spi_irq = 1'b1; spi_rdat = pdat; end
            end
            if (spi_cs && spi_we && spi_addr) begin
                resp_idx++;
                pend = lat;
                if (resp_idx >= 5 && flash_q.size() > 0) pdat = flash_q.pop_front();
                else pdat = 8'h5A ^ 8'(resp_idx);
            end else if (spi_cs && spi_we && !spi_addr && spi_dat == 8'h00) begin
                resp_idx = 0;
            end
        end
    end

    // Consumer: ready always, or held low 20 cycles per byte while stalling.
    int unsigned stall_ctr = 0;
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!stall) ready = 1'b1;
            else if (valid) begin
                if (stall_ctr >= 20) begin ready = 1'b1; stall_ctr = 0; end
                else begin ready = 1'b0; stall_ctr++; end
            end else ready = 1'b0;
        end
    end

    // Monitor: compares every observable cycle against the expected model.
    int unsigned mon_idx = 0;
    logic armed = 0, wait_irq = 0, irq_prev = 0, hs_prev = 0, desel_prev = 0;
    logic vprev = 0, rprev = 0;
    logic [7:0] dprev = 0;
    logic [2:0] hs_expect = 0;
    always @(negedge clk) begin
        if (rst) begin
            armed = 0; wait_irq = 0; mon_idx = 0; irq_prev = 0; hs_prev = 0;
            desel_prev = 0; vprev = 0;
        end else begin
            if (irq_prev && armed) begin
                if (mon_idx >= 5) chk("rx_irq_to_valid", valid, 1);
                else chk("irq_to_next_write", {spi_cs, spi_we, spi_addr}, 3'b111);
                armed = 0;
            end
            if (hs_prev) chk("handshake_to_write", {spi_cs, spi_we, spi_addr}, hs_expect);
            if (desel_prev) chk("desel_to_done", done, 1);
            if (vprev && !rprev && valid) chk("data_hold", data, dprev);
            if (valid && !vprev) chk("valid_expected", exp_rx.size() > 0, 1);
            if (valid) chk("bus_quiet_in_out", {spi_cs, spi_we}, 0);
            if (!busy) chk("idle_bus", {spi_cs, spi_we}, 0);
            if (spi_cs && spi_we) begin
                if (exp_wr.size() == 0) chk("write_count", 0, 1);
                else chk("bus_write", {spi_addr, spi_dat}, exp_wr.pop_front());
                if (spi_addr) begin
                    chk("write_before_irq", wait_irq, 0);
                    wait_irq = 1; armed = 1; mon_idx++;
                end else if (spi_dat == 8'h00) mon_idx = 0;
            end
            desel_prev = spi_cs && spi_we && !spi_addr && spi_dat == 8'h01 && mon_idx >= 5;
            if (spi_irq) wait_irq = 0;
            irq_prev = spi_irq;
            hs_prev = valid && ready;
            if (hs_prev) begin
                if (exp_rx.size() == 0) chk("stream_length", 0, 1);
                else chk("stream_byte", data, exp_rx.pop_front());
                hs_expect = (exp_rx.size() > 0) ? 3'b111 : 3'b110;
            end
            vprev = valid; rprev = ready; dprev = data;
            if (done) done_cnt++;
        end
    end

    task automatic build_read(input logic [23:0] a, input int unsigned n);
        exp_wr.push_back({1'b0, 8'h00});
        exp_wr.push_back({1'b1, 8'h03});
        exp_wr.push_back({1'b1, a[23:16]});
        exp_wr.push_back({1'b1, a[15:8]});
        exp_wr.push_back({1'b1, a[7:0]});
        for (int unsigned i = 0; i < n; i++) exp_wr.push_back({1'b1, 8'h00});
        exp_wr.push_back({1'b0, 8'h01});
    endtask

    task automatic load(input logic [7:0] b);
        flash_q.push_back(b);
        exp_rx.push_back(b);
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [15:0] n);
        faddr = a; len = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_to_sel_write", {spi_cs, spi_we, spi_addr, spi_dat}, {3'b110, 8'h00});
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        int unsigned d0 = done_cnt;
        for (int unsigned i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        chk({name, "_done_pulses"}, done_cnt - d0, 1);
        chk({name, "_busy_after"}, busy, 0);
        chk({name, "_writes_left"}, exp_wr.size(), 0);
        chk({name, "_bytes_left"}, exp_rx.size(), 0);
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_busy"}, busy, 1);
        chk({name, "_done"}, done, 0);
        chk({name, "_valid"}, valid, 0);
        chk({name, "_data"}, data, 8'h00);
        chk({name, "_bus"}, {spi_cs, spi_we, spi_addr, spi_dat}, 11'h000);
    endtask

    task automatic check_init_sequence(input string name);
        @(posedge clk); #1;
        chk({name, "_init_write"}, {spi_cs, spi_we, spi_addr, spi_dat}, {3'b110, 8'h01});
        chk({name, "_init_busy"}, busy, 1);
        @(posedge clk); #1;
        chk({name, "_busy_fall"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned d0;
        rst = 1'b1; start = 1'b0; faddr = '0; len = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        exp_wr.push_back({1'b0, 8'h01});
        rst = 1'b0;
        check_init_sequence("reset");
        repeat (10) @(posedge clk);
        #1;
        chk("reset_one_ctl_write", exp_wr.size(), 0);

        // Basic read, consumer always ready.
        build_read(24'h123456, 3);
        load(8'hA1); load(8'hB2); load(8'hC3);
        pulse_start(24'h123456, 16'd3);
        wait_done("read3", 500);

        // Same read with 20-cycle consumer stalls.
        stall = 1'b1;
        build_read(24'h123456, 3);
        load(8'hA1); load(8'hB2); load(8'hC3);
        pulse_start(24'h123456, 16'd3);
        wait_done("stall", 2000);
        stall = 1'b0;

        // Zero-length request.
        d0 = done_cnt;
        faddr = 24'hABCDEF; len = 16'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("len0_busy", busy, 1);
        chk("len0_done_early", done, 0);
        @(posedge clk); #1;
        chk("len0_done_at_2", done, 1);
        @(posedge clk); #1;
        chk("len0_done_one_cycle", done, 0);
        chk("len0_busy_low", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("len0_done_pulses", done_cnt - d0, 1);

        // Start pulsed mid-transfer must be ignored.
        lat = 5;
        build_read(24'hFF0010, 2);
        load(8'h3C); load(8'hC3);
        pulse_start(24'hFF0010, 16'd2);
        repeat (20) @(posedge clk);
        #1;
        faddr = 24'h000001; len = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("midstart", 500);
        repeat (20) @(posedge clk);
        #1;
        chk("midstart_no_second_done", busy, 0);

        // Reset while waiting on the A1 irq; the stale irq must be ignored.
        lat = 8;
        d0 = done_cnt;
        build_read(24'h0A0B0C, 2);
        load(8'h11); load(8'h22);
        pulse_start(24'h0A0B0C, 16'd2);
        for (int unsigned i = 0; i < 200 && resp_idx != 3; i++) @(negedge clk);
        chk("reach_a1_write", resp_idx, 3);
        @(posedge clk); #1;
        exp_wr.delete(); exp_rx.delete(); flash_q.delete();
        exp_wr.push_back({1'b0, 8'h01});
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("midreset");
        rst = 1'b0;
        check_init_sequence("midreset");
        repeat (40) @(posedge clk);
        #1;
        chk("midreset_valid", valid, 0);
        chk("midreset_no_done", done_cnt - d0, 0);
        chk("midreset_writes_left", exp_wr.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Sequencer that streams bytes out of a standard SPI NOR flash by driving the register port of the `spi` master peripheral in place of the CPU. It issues a READ (0x03) command with a 24-bit address, clocks in a requested number of data bytes, and delivers them on a valid/ready byte stream. It sits directly upstream of `spi` (as its bus master) and downstream of the boot/DMA logic that requests flash reads.

## Interface

Parameters:
- LEN_W, 16, width of the byte-count input

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_start  in  1  start request, sampled in IDLE only
- i_faddr  in  24  flash start address, latched on accepted start
- i_len  in  LEN_W  number of bytes to read, latched on accepted start
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when a request completes
- o_data  out  8  received byte
- o_valid  out  1  o_data valid; held until i_ready
- i_ready  in  1  consumer accepts byte when o_valid && i_ready
- o_spi_addr  out  1  to spi i_addr (0 = ctl/status, 1 = rx/tx)
- o_spi_cs  out  1  to spi i_cs
- o_spi_we  out  1  to spi i_we
- o_spi_dat  out  8  to spi i_dat
- i_spi_dat  in  8  from spi o_dat
- i_spi_irq  in  1  from spi o_irq (one-cycle end-of-byte pulse)

## Operation

- Flash chip-select is active-low on the spi `ss` bit: ctl write 0x00 = select, 0x01 = deselect.
- A ctl write is one cycle with o_spi_cs=1, o_spi_we=1, o_spi_addr=0. A byte transfer starts with a one-cycle write with o_spi_cs=1, o_spi_we=1, o_spi_addr=1, o_spi_dat=byte. It completes on i_spi_irq.
- While waiting for irq: o_spi_cs=1, o_spi_we=0, o_spi_addr=1. On the irq cycle, i_spi_dat holds the received byte and is captured that cycle.
- Never write the rx/tx register again until irq for the previous byte has been seen.
- States:
  - INIT: entered from reset. Writes ctl 0x01, then goes to IDLE.
  - IDLE: on i_start, latch i_faddr and i_len. If len==0, go to FIN. Otherwise go to SEL.
  - SEL: write ctl 0x00, then go to CMD.
  - CMD, A2, A1, A0: each is a write then a wait for irq. Bytes sent: 0x03, then faddr[23:16], faddr[15:8], faddr[7:0]. Received bytes are discarded.
  - RD: write 0x00, wait for irq, capture into o_data, go to OUT.
  - OUT: o_valid=1. On i_ready, decrement the remaining count. If the count is nonzero go to RD, else go to DESEL.
  - DESEL: write ctl 0x01, then go to FIN.
  - FIN: o_done=1 for one cycle, then go to IDLE.
- i_start outside IDLE is ignored. The spi bus is idle (cs=0, we=0) in IDLE and FIN.
- The remaining count is LEN_W bits and is decremented only on handshake. The maximum read is 2^LEN_W−1 bytes.
- Flash address wrap-around is handled by the flash. This block sends the address unchanged.

## Timing

- Reset values: o_busy=1 (INIT), o_done=0, o_valid=0, o_data=0x00, o_spi_cs=0, o_spi_we=0, o_spi_addr=0, o_spi_dat=0x00.
- Reset at any time, including mid-transfer or while o_valid is high, forces INIT the next cycle. INIT deselects the flash before returning to IDLE.
- Accepted i_start to first SEL write: 1 cycle (SEL is the cycle after start).
- irq cycle to next rx/tx write: exactly 1 cycle. The write happens in the cycle after irq, when spi is back in IDLE.
- RD irq to o_valid high: 1 cycle. o_data is stable while o_valid is high.
- Handshake to next RD write: 1 cycle. Last handshake to DESEL write: 1 cycle. DESEL to o_done: 1 cycle.
- len==0: o_done is asserted 2 cycles after i_start, with no spi bus activity.
- No combinational path from i_ready to any output. All outputs are registered.

## Test plan

- Reset, then idle: exactly one ctl write of 0x01 after reset release; o_busy falls the cycle after; no further bus activity.
- i_start with faddr=0x123456, len=3; flash model returns 0xA1, 0xB2, 0xC3; i_ready=1 -> bus writes 0x00(ctl), then 0x03, 0x12, 0x34, 0x56, 0x00, 0x00, 0x00, then 0x01(ctl). Stream 0xA1, 0xB2, 0xC3. One o_done pulse.
- Same read with i_ready held low 20 cycles per byte -> o_data held stable, no rx/tx write during the stall, same byte stream.
- i_start with len=0 -> o_done 2 cycles later; no spi writes; o_busy low again after FIN.
- Second i_start pulsed mid-transfer -> ignored; only one o_done; byte count matches the first request.
- i_reset asserted while waiting on irq in A1 -> outputs return to reset values. INIT writes ctl 0x01. The stale irq arriving later causes no capture or o_valid.
